button_input_bank: RTL
======================

// Module: button_input_bank
// PURPOSE
//  Parametrised N-channel push-button front end for the maze game: synchroniser,
//  debouncer, press/release edge pulses and optional per-channel auto-repeat while held.
//  Replaces the individual per-button debouncer instances in the top level.
//  Feeds maze_controller one-cycle move/control pulses and held levels.
// PARAMETERS
//  NUM_BTN          5           number of button channels
//  SYNC_STAGES      2           input synchroniser flops per channel (>=2)
//  DEBOUNCE_CYCLES  500000      consecutive stable cycles before a level change is accepted (20 ms @25 MHz, >=1)
//  REPEAT_DELAY     12500000    cycles from the press pulse to the first repeat pulse (0.5 s, >=1)
//  REPEAT_RATE      2500000     cycles between subsequent repeat pulses (0.1 s, >=1)
// PORTS
//  clk          in   1        system clock (25 MHz pixel clock)
//  rst          in   1        synchronous active-high reset
//  i_buttons    in   NUM_BTN  raw asynchronous button inputs, 1 = pressed
//  i_repeat_en  in   NUM_BTN  per-channel auto-repeat enable
//  o_level      out  NUM_BTN  debounced button level
//  o_pulse      out  NUM_BTN  one-cycle pulse on press and on each auto-repeat
//  o_release    out  NUM_BTN  one-cycle pulse on debounced release
//  o_any_pulse  out  1        OR of o_pulse, registered in the same cycle as o_pulse
// BEHAVIOUR
//  Reset: all outputs 0; synchronisers, debounce counters and repeat counters 0; FSMs IDLE.
//  Sync: sync_q = i_buttons delayed SYNC_STAGES cycles; no other logic samples i_buttons.
//  Debounce, per channel: cnt clears whenever sync_q == o_level; otherwise it increments.
//   When cnt == DEBOUNCE_CYCLES-1 while still mismatched: o_level <= sync_q and cnt <= 0.
//   Latency: a clean input edge appears on o_level SYNC_STAGES+DEBOUNCE_CYCLES cycles later.
//   Any bounce shorter than DEBOUNCE_CYCLES restarts the count; o_level never toggles on it.
//  Edges: o_pulse rises in the same cycle o_level rises 0->1.
//   o_release rises in the same cycle o_level falls 1->0. Both are registered and 1 cycle wide.
//  Repeat FSM, per channel, with rcnt width $clog2(max(REPEAT_DELAY,REPEAT_RATE)):
//   IDLE:   when o_level rises and i_repeat_en=1 -> DELAY, rcnt=0.
//   DELAY:  rcnt++ each cycle; when rcnt == REPEAT_DELAY-1, pulse next cycle, -> REPEAT, rcnt=0.
//   REPEAT: rcnt++; when rcnt == REPEAT_RATE-1, pulse next cycle, rcnt=0.
//   DELAY/REPEAT -> IDLE if o_level=0 or i_repeat_en=0.
//    That check takes priority over a coincident repeat pulse: no pulse is issued.
//   With i_repeat_en=0 a held button yields exactly one o_pulse.
//  Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.
//  A press pulse and a repeat pulse can never coincide on one channel.
//  Reset mid-operation: everything returns to reset values on the next edge.
//   A button still held after rst deasserts is treated as a new press after the full latency.
//  Buttons held through reset release behave as a fresh press; no pulse is issued during reset.
// TESTING (bench params: NUM_BTN=5, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
//  1. i_buttons[0]=1 from cycle 0, repeat off
//     -> o_level[0] and o_pulse[0] high at cycle 6; o_pulse[0] low at cycle 7; no further pulses.
//  2. i_buttons[2] toggles every 2 cycles for 20 cycles, then held 1
//     -> o_level[2] stays 0 during the bounce; exactly one o_pulse[2], 6 cycles after it settles.
//  3. i_repeat_en[1]=1, button held; press pulse at cycle t
//     -> repeat pulses at t+10, t+13, t+16.
//     Release -> o_release[1] 6 cycles later and no further pulses.
//  4. i_repeat_en[3] dropped to 0 while in REPEAT -> no further o_pulse[3]; o_level[3] stays 1.
//  5. All 5 buttons pressed in the same cycle
//     -> o_pulse = 5'h1F for exactly one cycle; o_any_pulse high in that same cycle.
//  6. rst asserted for 1 cycle mid-REPEAT with the button held
//     -> all outputs 0 the next cycle; new press pulse 6 cycles after rst release.

Source files
------------

// File: rtl/button_input_bank.sv
// N-channel push-button front end: input synchroniser, debouncer, press/release
// pulses and optional per-channel auto-repeat while a button is held.
module button_input_bank #(
  parameter int NUM_BTN         = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 2500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] i_buttons,
  input  logic [NUM_BTN-1:0] i_repeat_en,
  output logic [NUM_BTN-1:0] o_level,
  output logic [NUM_BTN-1:0] o_pulse,
  output logic [NUM_BTN-1:0] o_release,
  output logic               o_any_pulse
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RC_W    = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] DELAY_LAST = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RATE_LAST  = RC_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  logic [NUM_BTN-1:0] sync_r [SYNC_STAGES];
  logic [NUM_BTN-1:0] sync_q_s;
  logic [NUM_BTN-1:0] level_s;
  logic [NUM_BTN-1:0] pulse_s;
  logic [NUM_BTN-1:0] release_s;
  logic [NUM_BTN-1:0] pulse_next_s;
  logic               any_pulse_r;

  // Synchroniser shift chain; the only logic that samples i_buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= '0;
      end
    end else begin
      sync_r[0] <= i_buttons;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  assign sync_q_s = sync_r[SYNC_STAGES-1];

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    logic            level_r;
    logic            pulse_r;
    logic            release_r;
    logic [DB_W-1:0] cnt_r;
    logic            accept_s;
    logic            rise_s;
    logic            fall_s;
    logic            rpt_pulse_s;
    rpt_state_t      state_r;
    rpt_state_t      state_s;
    logic [RC_W-1:0] rcnt_r;
    logic [RC_W-1:0] rcnt_s;

    assign accept_s = (sync_q_s[g] != level_r) && (cnt_r == DB_LAST);
    assign rise_s   = accept_s && sync_q_s[g];
    assign fall_s   = accept_s && !sync_q_s[g];

    // Debounce: count consecutive mismatching cycles, adopt the new level on the last one.
    always_ff @(posedge clk) begin
      if (rst) begin
        level_r <= 1'b0;
        cnt_r   <= '0;
      end else if (sync_q_s[g] == level_r) begin
        cnt_r <= '0;
      end else if (accept_s) begin
        level_r <= sync_q_s[g];
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + DB_W'(1);
      end
    end

    // Auto-repeat state and interval counter registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r <= IDLE;
        rcnt_r  <= '0;
      end else begin
        state_r <= state_s;
        rcnt_r  <= rcnt_s;
      end
    end

    // Auto-repeat next state; losing the level or the enable beats a due repeat pulse.
    always_comb begin
      state_s     = state_r;
      rcnt_s      = rcnt_r;
      rpt_pulse_s = 1'b0;
      case (state_r)
        IDLE: begin
          if (rise_s && i_repeat_en[g]) begin
            state_s = DELAY;
            rcnt_s  = '0;
          end else begin
            state_s = IDLE;
          end
        end
        DELAY: begin
          if (!level_r || !i_repeat_en[g]) begin
            state_s = IDLE;
            rcnt_s  = '0;
          end else if (rcnt_r == DELAY_LAST) begin
            state_s     = REPEAT;
            rcnt_s      = '0;
            rpt_pulse_s = 1'b1;
          end else begin
            rcnt_s = rcnt_r + RC_W'(1);
          end
        end
        REPEAT: begin
          if (!level_r || !i_repeat_en[g]) begin
            state_s = IDLE;
            rcnt_s  = '0;
          end else if (rcnt_r == RATE_LAST) begin
            rcnt_s      = '0;
            rpt_pulse_s = 1'b1;
          end else begin
            rcnt_s = rcnt_r + RC_W'(1);
          end
        end
        default: begin
          state_s = IDLE;
          rcnt_s  = '0;
        end
      endcase
    end

    // Registered one-cycle event outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        pulse_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        pulse_r   <= rise_s | rpt_pulse_s;
        release_r <= fall_s;
      end
    end

    assign level_s[g]      = level_r;
    assign pulse_s[g]      = pulse_r;
    assign release_s[g]    = release_r;
    assign pulse_next_s[g] = rise_s | rpt_pulse_s;
  end

  // Any-pulse flag registered alongside the per-channel pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_pulse_r <= 1'b0;
    end else begin
      any_pulse_r <= |pulse_next_s;
    end
  end

  assign o_level     = level_s;
  assign o_pulse     = pulse_s;
  assign o_release   = release_s;
  assign o_any_pulse = any_pulse_r;

endmodule
